// File: rtl/paddle_ctrl.sv
// Pong paddle controller: moves two paddles from held keys on each frame tick.
// Optional hold-to-accelerate is compiled in with PADDLE_ACCEL_EN.

module paddle_unit #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 80,
`ifdef PADDLE_ACCEL_EN
  parameter int MAX_SPEED   = 12,
  parameter int ACCEL_TICKS = 8,
`endif
  parameter int SPEED       = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       up,
  input  logic       down,
  input  logic       tick,
  input  logic       freeze,
  input  logic       center,
  output logic [9:0] y,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} st_e;

  localparam logic [9:0] MAX_Y  = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] INIT_Y = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] STEP0  = 10'(SPEED);

  st_e         state_q, state_d, dir;
  logic [9:0]  y_q, y_d, mv_step;
  logic [10:0] sum;

`ifdef PADDLE_ACCEL_EN
  localparam logic [9:0] MAXS = 10'(MAX_SPEED);
  localparam logic [7:0] ACC  = 8'(ACCEL_TICKS);

  logic [9:0]  step_q, step_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [10:0] step_sum;
`endif

  always_comb begin
    if (up && !down)      dir = UP;
    else if (down && !up) dir = DOWN;
    else                  dir = IDLE;
  end

  always_comb begin
    y_d     = y_q;
    state_d = state_q;
`ifdef PADDLE_ACCEL_EN
    step_d   = step_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 8'd1;
    step_sum = {1'b0, step_q} + {1'b0, STEP0};
    // A continuing direction keeps its accumulated step; a new one restarts at SPEED.
    mv_step  = (dir == state_q) ? step_q : STEP0;
`else
    mv_step  = STEP0;
`endif
    sum = {1'b0, y_q} + {1'b0, mv_step};

    if (center) begin
      y_d     = INIT_Y;
      state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
      step_d  = STEP0;
      cnt_d   = 8'd0;
`endif
    end else if (freeze) begin
      state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
      step_d  = STEP0;
      cnt_d   = 8'd0;
`endif
    end else if (tick) begin
      state_d = dir;
      case (dir)
        UP:      y_d = (y_q < mv_step) ? 10'd0 : y_q - mv_step;
        DOWN:    y_d = (sum > {1'b0, MAX_Y}) ? MAX_Y : sum[9:0];
        default: y_d = y_q;
      endcase
`ifdef PADDLE_ACCEL_EN
      if (dir == IDLE) begin
        step_d = STEP0;
        cnt_d  = 8'd0;
      end else if (dir != state_q) begin
        step_d = STEP0;
        cnt_d  = 8'd1;
      end else if (cnt_inc == ACC) begin
        cnt_d  = 8'd0;
        step_d = (step_sum > {1'b0, MAXS}) ? MAXS : step_sum[9:0];
      end else begin
        cnt_d  = cnt_inc;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_q     <= INIT_Y;
      state_q <= IDLE;
`ifdef PADDLE_ACCEL_EN
      step_q  <= STEP0;
      cnt_q   <= 8'd0;
`endif
    end else begin
      y_q     <= y_d;
      state_q <= state_d;
`ifdef PADDLE_ACCEL_EN
      step_q  <= step_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign y     = y_q;
  assign state = state_q;
endmodule

module paddle_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 80,
  parameter int SPEED       = 4,
  parameter int MAX_SPEED   = 12,
  parameter int ACCEL_TICKS = 8
) (
  input  logic       paddle_clk,
  input  logic       paddle_rstn,
  input  logic [3:0] paddle_keys,
  input  logic       paddle_tick,
  input  logic       paddle_freeze,
  input  logic       paddle_center,
  output logic [9:0] paddle_left_y,
  output logic [9:0] paddle_right_y,
  output logic [3:0] paddle_state
);
  localparam bit PARAMS_OK = (SPEED >= 1) && (MAX_SPEED >= SPEED) &&
                             (SPEED <= SCREEN_H - PADDLE_H) &&
                             (ACCEL_TICKS >= 2) && (ACCEL_TICKS <= 255);

  logic [3:0]       key_q, key_d;
  logic [1:0][9:0]  y_all;
  logic [1:0][1:0]  st_all;

  always_comb key_d = paddle_keys;

  always_ff @(posedge paddle_clk) begin
    if (!paddle_rstn) key_q <= 4'd0;
    else              key_q <= key_d;
  end

  // Unit 0 is the left paddle (W/S on keys[3:2]), unit 1 the right (arrows on keys[1:0]).
  for (genvar g = 0; g < 2; g++) begin : g_pad
    localparam int KB = (g == 0) ? 2 : 0;
    paddle_unit #(
      .SCREEN_H   (SCREEN_H),
      .PADDLE_H   (PADDLE_H),
`ifdef PADDLE_ACCEL_EN
      .MAX_SPEED  (MAX_SPEED),
      .ACCEL_TICKS(ACCEL_TICKS),
`endif
      .SPEED      (SPEED)
    ) u_pad (
      .clk   (paddle_clk),
      .rstn  (paddle_rstn),
      .up    (key_q[KB]),
      .down  (key_q[KB+1]),
      .tick  (paddle_tick),
      .freeze(paddle_freeze),
      .center(paddle_center),
      .y     (y_all[g]),
      .state (st_all[g])
    );
  end

  assign paddle_left_y  = y_all[0];
  assign paddle_right_y = y_all[1];
  assign paddle_state   = {st_all[1], st_all[0]};

  always_ff @(posedge paddle_clk) begin
    assert (PARAMS_OK) else $error("paddle_ctrl: illegal parameter combination");
  end
endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed literal checks plus randomized
// stimulus compared every cycle against a run-length based paddle model.

module tb_paddle_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] keys = 4'd0;
  logic       tick = 1'b0, freeze = 1'b0, center = 1'b0;
  logic [9:0] left_y, right_y;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int my[2], mst[2], mrun[2];
  logic [3:0] mkey;

  paddle_ctrl dut (
    .paddle_clk    (clk),
    .paddle_rstn   (rstn),
    .paddle_keys   (keys),
    .paddle_tick   (tick),
    .paddle_freeze (freeze),
    .paddle_center (center),
    .paddle_left_y (left_y),
    .paddle_right_y(right_y),
    .paddle_state  (state)
  );

  always #5 clk = ~clk;

  // Step size as a function of how many consecutive same-direction ticks have occurred.
  function automatic int step_for(input int run);
`ifdef PADDLE_ACCEL_EN
    int s;
    s = 4 + 4 * ((run - 1) / 8);
    return (s > 12) ? 12 : s;
`else
    return 4;
`endif
  endfunction

  task automatic model_update(input logic r, input logic [3:0] k, input logic t,
                              input logic f, input logic c);
    int up, dn, d, s;
    if (!r) begin
      for (int p = 0; p < 2; p++) begin my[p] = 200; mst[p] = 0; mrun[p] = 0; end
      mkey = 4'd0;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      up = (p == 0) ? int'(mkey[2]) : int'(mkey[0]);
      dn = (p == 0) ? int'(mkey[3]) : int'(mkey[1]);
      if (c) begin
        my[p] = 200; mst[p] = 0; mrun[p] = 0;
      end else if (f) begin
        mst[p] = 0; mrun[p] = 0;
      end else if (t) begin
        d = (up == 1 && dn == 0) ? 1 : (dn == 1 && up == 0) ? 2 : 0;
        if (d == 0)           mrun[p] = 0;
        else if (d == mst[p]) mrun[p] = mrun[p] + 1;
        else                  mrun[p] = 1;
        mst[p] = d;
        s = step_for(mrun[p]);
        if (d == 1) my[p] = (my[p] - s < 0) ? 0 : my[p] - s;
        if (d == 2) my[p] = (my[p] + s > 400) ? 400 : my[p] + s;
      end
    end
    mkey = k;
  endtask

  task automatic cyc(input logic r, input logic [3:0] k, input logic t,
                     input logic f, input logic c);
    rstn = r; keys = k; tick = t; freeze = f; center = c;
    @(posedge clk);
    model_update(r, k, t, f, c);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_left_y", int'(left_y), my[0]);
      check("model_right_y", int'(right_y), my[1]);
      check("model_state", int'(state), (mst[1] << 2) | mst[0]);
    end
  end

  initial begin
    cyc(0, 4'd0, 0, 0, 0);
    cyc(0, 4'b1111, 1, 1, 1);
    check("reset_left", int'(left_y), 200);
    check("reset_right", int'(right_y), 200);
    check("reset_state", int'(state), 0);
    chk_en = 1'b1;

    cyc(1, 4'd0, 1, 0, 0);
    check("idle_tick_left", int'(left_y), 200);
    check("idle_tick_state", int'(state), 0);

    // Hold W: key reaches decode one cycle later.
    cyc(1, 4'b0100, 0, 0, 0);
    cyc(1, 4'b0100, 1, 0, 0); check("w_tick1", int'(left_y), 196);
    cyc(1, 4'b0100, 1, 0, 0); check("w_tick2", int'(left_y), 192);
    cyc(1, 4'b0100, 1, 0, 0); check("w_tick3", int'(left_y), 188);
    check("w_state_left", int'(state[1:0]), 1);
    check("w_right_y", int'(right_y), 200);

    cyc(1, 4'b0011, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 4'b0011, 1, 0, 0);
    check("both_arrows_right", int'(right_y), 200);
    check("both_arrows_state", int'(state[3:2]), 0);

    cyc(1, 4'b1000, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(1, 4'b1000, 1, 0, 0);
    check("clamp_bottom", int'(left_y), 400);
    check("clamp_bottom_state", int'(state[1:0]), 2);
    cyc(1, 4'b1000, 1, 0, 0);
    check("clamp_bottom_hold", int'(left_y), 400);

    cyc(1, 4'b0100, 0, 0, 0);
    for (int i = 0; i < 110; i++) cyc(1, 4'b0100, 1, 0, 0);
    check("clamp_top", int'(left_y), 0);

    cyc(1, 4'b1000, 0, 0, 0);
    cyc(1, 4'b1000, 1, 0, 1);
    check("center_tick_left", int'(left_y), 200);
    check("center_tick_state", int'(state), 0);
    for (int i = 0; i < 10; i++) cyc(1, 4'b1000, 1, 1, 0);
    check("freeze_left", int'(left_y), 200);
    check("freeze_state", int'(state), 0);

    for (int i = 0; i < 8; i++) cyc(1, 4'b1000, 1, 0, 0);
    check("s_8_ticks", int'(left_y), 232);
    cyc(1, 4'b1000, 1, 0, 0);
`ifdef PADDLE_ACCEL_EN
    check("s_tick9", int'(left_y), 240);
`else
    check("s_tick9", int'(left_y), 236);
`endif
    for (int i = 0; i < 15; i++) cyc(1, 4'b1000, 1, 0, 0);
`ifdef PADDLE_ACCEL_EN
    check("s_24_ticks", int'(left_y), 392);
`else
    check("s_24_ticks", int'(left_y), 296);
`endif
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 1, 0, 0);
    cyc(1, 4'b1000, 0, 0, 0);
    cyc(1, 4'b1000, 1, 0, 0);
`ifdef PADDLE_ACCEL_EN
    check("s_repress", int'(left_y), 396);
`else
    check("s_repress", int'(left_y), 300);
`endif

    begin
      logic [3:0] k;
      k = 4'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) k = 4'($urandom);
        cyc(($urandom_range(0, 299) != 0), k, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
